// File: rtl/cordic_sweep_sequencer.sv
// Frequency-sweep controller for the CORDIC waveform core; retunes only on phase-wrap events.
// Latency: start -> outputs next cycle; dwell-completing wrap -> new freq two cycles later. No backpressure.
module cordic_sweep_sequencer #(
  parameter int FREQ_W  = 13,
  parameter int DWELL_W = 16
) (
  input  logic               clk1,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         wave_cfg,
  input  logic               phase_wrap,
  output logic [FREQ_W-1:0]  freq,
  output logic [1:0]         waveform_sel,
  output logic               busy,
  output logic               dir,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [FREQ_W-1:0]    freq_q, freq_d;
  logic [1:0]           wsel_q, wsel_d;
  logic                 dir_q, dir_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   target_q, target_d;
  logic [FREQ_W-1:0]    lo_q, lo_d;
  logic [FREQ_W-1:0]    hi_q, hi_d;
  logic [FREQ_W-1:0]    step_q, step_d;
  logic [1:0]           mode_q, mode_d;

  logic [FREQ_W:0]      up_sum;
  logic [FREQ_W:0]      dn_diff;
  logic [FREQ_W-1:0]    up_nxt;
  logic [FREQ_W-1:0]    dn_nxt;
  logic [DWELL_W:0]     cnt_inc;
  logic                 at_hi;
  logic                 at_lo;
  logic                 new_dir;

  // Clamped step candidates; one extra bit catches overflow and underflow.
  always_comb begin
    up_sum  = {1'b0, freq_q} + {1'b0, step_q};
    dn_diff = {1'b0, freq_q} - {1'b0, step_q};
    up_nxt  = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[FREQ_W-1:0];
    dn_nxt  = (dn_diff[FREQ_W] || (dn_diff[FREQ_W-1:0] < lo_q)) ? lo_q : dn_diff[FREQ_W-1:0];
    cnt_inc = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, phase_wrap};
    at_hi   = (freq_q == hi_q);
    at_lo   = (freq_q == lo_q);
    new_dir = at_hi ? 1'b0 : (at_lo ? 1'b1 : dir_q);
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    wsel_d   = wsel_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    step_d   = step_q;
    mode_d   = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          lo_d     = (f_start > f_stop) ? f_stop : f_start;
          hi_d     = (f_start > f_stop) ? f_start : f_stop;
          step_d   = f_step;
          mode_d   = mode;
          target_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          freq_d   = (f_start > f_stop) ? f_stop : f_start;
          wsel_d   = wave_cfg;
          dir_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_DWELL;
        end
      end

      S_DWELL: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_inc >= {1'b0, target_q}) begin
          // A wrap carried over from STEP can already satisfy a dwell of 1.
          cnt_d   = '0;
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_inc[DWELL_W-1:0];
        end
      end

      S_STEP: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = phase_wrap ? DWELL_W'(1) : '0;
          state_d = S_DWELL;
          if (mode_q != 2'b11 && step_q != '0) begin
            case (mode_q)
              2'b00: begin
                if (at_hi) state_d = S_DONE;
                else       freq_d  = up_nxt;
              end
              2'b01:   freq_d = at_hi ? lo_q : up_nxt;
              default: begin
                dir_d  = new_dir;
                freq_d = new_dir ? up_nxt : dn_nxt;
              end
            endcase
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      freq_q   <= '0;
      wsel_q   <= '0;
      dir_q    <= 1'b1;
      cnt_q    <= '0;
      target_q <= DWELL_W'(1);
      lo_q     <= '0;
      hi_q     <= '0;
      step_q   <= '0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      wsel_q   <= wsel_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
    end
  end

  assign freq         = freq_q;
  assign waveform_sel = wsel_q;
  assign dir          = dir_q;
  assign busy         = (state_q == S_DWELL) || (state_q == S_STEP);
  assign done         = (state_q == S_DONE);

endmodule
